// File: rtl/cpu_bus_responder_pkg.sv
// rtl/cpu_bus_responder_pkg.sv - shared types and constants for the core bus responder
// Purpose: FSM state encoding, address-region decode and bus constants used by
//          cpu_bus_responder and its memory sub-module.
package cpu_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_RAM  = 2'd1,
    RGN_VRAM = 2'd2
  } region_e;

  localparam logic [19:0] VRAM_BASE_DEFAULT = 20'hB8000;
  localparam int          VRAM_AW           = 12;
  localparam int          VRAM_SIZE         = 4096;
  localparam logic [7:0]  UNMAPPED_RDATA    = 8'hFF;

  // RAM wins over the video window when the two overlap.
  function automatic region_e decode_region(input logic [19:0] addr,
                                            input int          ram_aw,
                                            input logic [19:0] vram_base);
    if ((addr >> ram_aw) == 20'd0) begin
      return RGN_RAM;
    end else if (addr[19:VRAM_AW] == vram_base[19:VRAM_AW]) begin
      return RGN_VRAM;
    end else begin
      return RGN_NONE;
    end
  endfunction

endpackage

// File: rtl/cpu_bus_responder_bus_dpram.sv
// rtl/cpu_bus_responder_bus_dpram.sv - byte RAM, falling-edge port A, rising-edge read port B
// Purpose: storage array shared by core/loader (port A) and a secondary reader (port B).
// Ports:
//   clock, reset   - system clock; reset only clears the port B output register
//   we_a_i         - port A write enable (falling edge)
//   waddr_a_i      - port A write address
//   wdata_a_i      - port A write data
//   raddr_a_i      - port A read address (falling edge)
//   rdata_a_o      - port A read data, old data on read-during-write
//   addr_b_i       - port B read address (rising edge)
//   rdata_b_o      - port B read data, one cycle latency
module bus_dpram #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_a_i,
  input  logic [AW-1:0] waddr_a_i,
  input  logic [7:0]    wdata_a_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] addr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] mem_q [2**AW];

  // Falling-edge access lets the core see read data within its own cycle.
  always_ff @(negedge clock) begin
    if (we_a_i) begin
      mem_q[waddr_a_i] <= wdata_a_i;
    end
    rdata_a_o <= mem_q[raddr_a_i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_b_o <= 8'h00;
    end else begin
      rdata_b_o <= mem_q[addr_b_i];
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - zero-wait-state memory responder with boot loader
// Purpose: decodes the core's 20-bit address into RAM and the video window,
//          answers reads within the same cycle, and streams a boot image in
//          while holding the core off the bus.
// Ports:
//   clock, reset             - system clock, synchronous active-high reset
//   cpu_address/rdata/wdata  - core byte bus; cpu_we is the write strobe
//   cpu_hold                 - core clock-enable hold while loading
//   ld_start/base/len        - begin a load of len bytes at base
//   ld_valid/data/ready      - loader byte handshake
//   vid_addr/vid_data        - scanner read port into video RAM
//   bus_err                  - sticky unmapped-write flag
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int          RAM_AW    = 16,
  parameter logic [19:0] VRAM_BASE = VRAM_BASE_DEFAULT,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] cpu_address,
  output logic [7:0]  cpu_rdata,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_hold,
  input  logic        ld_start,
  input  logic [19:0] ld_base,
  input  logic [15:0] ld_len,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic [11:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        bus_err
);

  state_e      state_q;
  logic        cpu_hold_q;
  logic        ld_ready_q;
  logic        bus_err_q;
  logic [19:0] ld_ptr_q;
  logic [15:0] ld_cnt_q;
  logic        ld_wr_q;
  logic [19:0] ld_waddr_q;
  logic [7:0]  ld_wdata_q;
  region_e     rd_rgn_q;

  logic        core_wr;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  region_e     wr_rgn;
  region_e     core_rgn;
  logic        ram_we;
  logic        vram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  vram_rdata;
  logic [7:0]  ram_b_unused;

  // A loader byte still committing on the falling edge after the final accept
  // owns the write port; the core has only just been released in that cycle.
  assign core_wr  = cpu_we & ~cpu_hold_q & ~ld_wr_q;
  assign wr_en    = ld_wr_q | core_wr;
  assign wr_addr  = ld_wr_q ? ld_waddr_q : cpu_address;
  assign wr_data  = ld_wr_q ? ld_wdata_q : cpu_wdata;
  assign wr_rgn   = decode_region(wr_addr, RAM_AW, VRAM_BASE);
  assign core_rgn = decode_region(cpu_address, RAM_AW, VRAM_BASE);
  assign ram_we   = wr_en & (wr_rgn == RGN_RAM);
  assign vram_we  = wr_en & (wr_rgn == RGN_VRAM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BOOT_LOAD ? ST_HOLD : ST_RUN;
      cpu_hold_q <= BOOT_LOAD;
      ld_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      ld_ptr_q   <= 20'h0;
      ld_cnt_q   <= 16'h0;
      ld_wr_q    <= 1'b0;
      ld_waddr_q <= 20'h0;
      ld_wdata_q <= 8'h00;
    end else begin
      ld_wr_q <= 1'b0;
      if (core_wr && (core_rgn == RGN_NONE)) begin
        bus_err_q <= 1'b1;
      end
      case (state_q)
        ST_HOLD, ST_RUN: begin
          if (ld_start) begin
            state_q    <= ST_LOAD;
            cpu_hold_q <= 1'b1;
            ld_ptr_q   <= ld_base;
            ld_cnt_q   <= ld_len;
            ld_ready_q <= (ld_len != 16'h0);
          end
        end
        ST_LOAD: begin
          if (ld_cnt_q == 16'h0) begin
            // Zero-length load: one LOAD cycle, then straight to RUN.
            state_q    <= ST_RUN;
            cpu_hold_q <= 1'b0;
            ld_ready_q <= 1'b0;
          end else if (ld_valid && ld_ready_q) begin
            ld_wr_q    <= 1'b1;
            ld_waddr_q <= ld_ptr_q;
            ld_wdata_q <= ld_data;
            ld_ptr_q   <= ld_ptr_q + 20'h1;
            ld_cnt_q   <= ld_cnt_q - 16'h1;
            if (decode_region(ld_ptr_q, RAM_AW, VRAM_BASE) == RGN_NONE) begin
              bus_err_q <= 1'b1;
            end
            if (ld_cnt_q == 16'h1) begin
              state_q    <= ST_RUN;
              cpu_hold_q <= 1'b0;
              ld_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= BOOT_LOAD ? ST_HOLD : ST_RUN;
          cpu_hold_q <= BOOT_LOAD;
          ld_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Region of the read captured on the same falling edge as the array data,
  // so the output mux and the array outputs always describe one address.
  always_ff @(negedge clock) begin
    if (reset) begin
      rd_rgn_q <= RGN_NONE;
    end else begin
      rd_rgn_q <= core_rgn;
    end
  end

  always_comb begin
    cpu_rdata = UNMAPPED_RDATA;
    case (rd_rgn_q)
      RGN_RAM:  cpu_rdata = ram_rdata;
      RGN_VRAM: cpu_rdata = vram_rdata;
      default:  cpu_rdata = UNMAPPED_RDATA;
    endcase
  end

  bus_dpram #(.AW(RAM_AW)) u_ram (
    .clock     (clock),
    .reset     (reset),
    .we_a_i    (ram_we),
    .waddr_a_i (wr_addr[RAM_AW-1:0]),
    .wdata_a_i (wr_data),
    .raddr_a_i (cpu_address[RAM_AW-1:0]),
    .rdata_a_o (ram_rdata),
    .addr_b_i  ({RAM_AW{1'b0}}),
    .rdata_b_o (ram_b_unused)
  );

  bus_dpram #(.AW(VRAM_AW)) u_vram (
    .clock     (clock),
    .reset     (reset),
    .we_a_i    (vram_we),
    .waddr_a_i (wr_addr[VRAM_AW-1:0]),
    .wdata_a_i (wr_data),
    .raddr_a_i (cpu_address[VRAM_AW-1:0]),
    .rdata_a_o (vram_rdata),
    .addr_b_i  (vid_addr),
    .rdata_b_o (vid_data)
  );

  assign cpu_hold = cpu_hold_q;
  assign ld_ready = ld_ready_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - directed self-checking bench for cpu_bus_responder
module tb_cpu_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_rdata;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_hold;
  logic        ld_start;
  logic [19:0] ld_base;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [11:0] vid_addr;
  logic [7:0]  vid_data;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  cpu_bus_responder #(
    .RAM_AW    (16),
    .VRAM_BASE (20'hB8000),
    .BOOT_LOAD (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_address (cpu_address),
    .cpu_rdata   (cpu_rdata),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_hold    (cpu_hold),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_len      (ld_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .bus_err     (bus_err)
  );

  always #20 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_read_check(input string tag, input logic [19:0] a, input logic [7:0] exp);
    cpu_address = a;
    tick();
    check_eq(tag, {24'h0, cpu_rdata}, {24'h0, exp});
  endtask

  task automatic cpu_write(input logic [19:0] a, input logic [7:0] d);
    cpu_address = a;
    cpu_wdata   = d;
    cpu_we      = 1'b1;
    tick();
    cpu_we      = 1'b0;
  endtask

  task automatic loader_start(input logic [19:0] base, input logic [15:0] len);
    ld_base  = base;
    ld_len   = len;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic loader_push(input string tag, input logic [7:0] d);
    for (int i = 0; i < 20 && !ld_ready; i++) tick();
    check_eq(tag, {31'h0, ld_ready}, 32'h1);
    ld_data  = d;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    cpu_address = 20'h0;
    cpu_wdata   = 8'h00;
    cpu_we      = 1'b0;
    ld_start    = 1'b0;
    ld_base     = 20'h0;
    ld_len      = 16'h0;
    ld_valid    = 1'b0;
    ld_data     = 8'h00;
    vid_addr    = 12'h000;

    // Reset values
    tick();
    tick();
    check_eq("rst_hold",     {31'h0, cpu_hold}, 32'h1);
    check_eq("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check_eq("rst_bus_err",  {31'h0, bus_err},  32'h0);
    check_eq("rst_rdata",    {24'h0, cpu_rdata}, 32'hFF);
    check_eq("rst_vid_data", {24'h0, vid_data},  32'h00);
    reset = 1'b0;
    tick();
    check_eq("hold_still", {31'h0, cpu_hold}, 32'h1);

    // Boot load of three bytes at 00100h
    loader_start(20'h00100, 16'd3);
    check_eq("load_hold", {31'h0, cpu_hold}, 32'h1);
    loader_push("ld_ready_b0", 8'hB8);
    loader_push("ld_ready_b1", 8'h34);
    loader_push("ld_ready_b2", 8'h12);
    check_eq("run_hold",     {31'h0, cpu_hold}, 32'h0);
    check_eq("run_ld_ready", {31'h0, ld_ready}, 32'h0);
    tick();
    cpu_read_check("rd_100", 20'h00100, 8'hB8);
    cpu_read_check("rd_101", 20'h00101, 8'h34);
    cpu_read_check("rd_102", 20'h00102, 8'h12);

    // Consecutive core writes into video RAM
    cpu_write(20'hB8000, 8'h5A);
    cpu_write(20'hB8001, 8'hA5);
    cpu_read_check("rd_b8000", 20'hB8000, 8'h5A);
    cpu_read_check("rd_b8001", 20'hB8001, 8'hA5);
    vid_addr = 12'h000;
    tick();
    check_eq("vid_000", {24'h0, vid_data}, 32'h5A);
    vid_addr = 12'h001;
    tick();
    check_eq("vid_001", {24'h0, vid_data}, 32'hA5);

    // Unmapped read then write
    cpu_write(20'h00000, 8'h00);
    cpu_write(20'h00010, 8'h3C);
    cpu_read_check("rd_unmapped", 20'h90000, 8'hFF);
    check_eq("no_err_on_read", {31'h0, bus_err}, 32'h0);
    cpu_write(20'h90000, 8'h77);
    check_eq("err_on_write", {31'h0, bus_err}, 32'h1);
    cpu_read_check("ram0_intact",  20'h00000, 8'h00);
    cpu_read_check("vram0_intact", 20'hB8000, 8'h5A);
    cpu_read_check("rd_unmapped2", 20'h90000, 8'hFF);
    tick();
    tick();
    check_eq("err_sticky", {31'h0, bus_err}, 32'h1);

    // Reset after one of three loader bytes; core write under hold ignored
    loader_start(20'h00200, 16'd3);
    check_eq("reload_hold", {31'h0, cpu_hold}, 32'h1);
    cpu_address = 20'h00010;
    cpu_wdata   = 8'hEE;
    cpu_we      = 1'b1;
    loader_push("ld_ready_p0", 8'hAA);
    cpu_we = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("midrst_hold",     {31'h0, cpu_hold}, 32'h1);
    check_eq("midrst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check_eq("midrst_bus_err",  {31'h0, bus_err},  32'h0);
    cpu_read_check("partial_kept",   20'h00200, 8'hAA);
    cpu_read_check("held_we_ignored", 20'h00010, 8'h3C);

    // Loader wrap from FFFFFh to 00000h
    loader_start(20'hFFFFF, 16'd2);
    loader_push("ld_ready_w0", 8'h11);
    check_eq("wrap_bus_err", {31'h0, bus_err}, 32'h1);
    loader_push("ld_ready_w1", 8'h22);
    check_eq("wrap_run_hold", {31'h0, cpu_hold}, 32'h0);
    tick();
    cpu_read_check("wrap_rd_0", 20'h00000, 8'h22);

    // Zero-length load: exactly one LOAD cycle
    loader_start(20'h00300, 16'd0);
    check_eq("len0_hold",     {31'h0, cpu_hold}, 32'h1);
    check_eq("len0_ld_ready", {31'h0, ld_ready}, 32'h0);
    tick();
    check_eq("len0_run_hold",  {31'h0, cpu_hold}, 32'h0);
    check_eq("len0_run_ready", {31'h0, ld_ready}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
